// File: rtl/alu_issue.sv
// alu_issue: command FIFO feeding a one-deep issue stage and a response register around an external combinational ALU.
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [3:0]  cmd_tag,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic        rsp_err,
  output logic        busy,
  output logic [15:0] op_count
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]  op_mem [DEPTH];
  logic [31:0] a_mem [DEPTH];
  logic [31:0] b_mem [DEPTH];
  logic [3:0]  tag_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic ex_valid;
  logic [3:0] ex_tag;
  logic full, empty, push, pop, rsp_free, ex_free, capture;
  // cmd_ready looks only at occupancy, never at a same-cycle pop
  always_comb begin
    full      = count == (AW+1)'(DEPTH);
    empty     = count == '0;
    cmd_ready = !full;
    push      = cmd_valid && !full;
    rsp_free  = !rsp_valid || rsp_ready;
    ex_free   = !ex_valid || rsp_free;
    pop       = !empty && ex_free;
    capture   = ex_valid && rsp_free;
    busy      = !empty || ex_valid || rsp_valid;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      a_mem[wr_ptr]   <= cmd_a;
      b_mem[wr_ptr]   <= cmd_b;
      tag_mem[wr_ptr] <= cmd_tag;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ex_valid   <= 1'b0;
      ex_tag     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (pop) begin
        ex_valid <= 1'b1;
        alu_op   <= op_mem[rd_ptr];
        alu_a    <= a_mem[rd_ptr];
        alu_b    <= b_mem[rd_ptr];
        ex_tag   <= tag_mem[rd_ptr];
      end else if (rsp_free) ex_valid <= 1'b0;
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_tag    <= ex_tag;
        rsp_err    <= alu_op > 4'd4;
      end else if (rsp_ready) rsp_valid <= 1'b0;
      if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
    end
  end
endmodule
